// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared helpers and parameter checks for the width-converting sync FIFO
package sync_fifo_pkg;

    function automatic int lanes_of(input int width, input int lane_w);
        return width / lane_w;
    endfunction

    function automatic int ptr_add(input int ptr, input int n, input int depth);
        return (ptr + n) % depth;
    endfunction

    // Legal configuration: power-of-two depth, integer width ratio, depth a multiple of the ratio.
    function automatic bit params_ok(input int depth, input int width_in, input int width_out);
        int lane_w;
        int ratio;
        lane_w = (width_in < width_out) ? width_in : width_out;
        ratio  = (width_in > width_out) ? width_in / lane_w : width_out / lane_w;
        return (depth > 0) && ((depth & (depth - 1)) == 0)
            && (lane_w > 0)
            && (((width_in > width_out) ? width_in : width_out) % lane_w == 0)
            && (depth % ratio == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_lane_mem.sv
// rtl/sync_fifo_lane_mem.sv - DEPTH x LANE_W flop array, multi-lane write port and combinational multi-lane read port
module sync_fifo_lane_mem
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int LANE_W     = 32,
    parameter int IN_LANES   = 1,
    parameter int OUT_LANES  = 4,
    parameter int LOG2_DEPTH = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [LOG2_DEPTH-1:0]         wr_ptr,
    input  logic [IN_LANES*LANE_W-1:0]    wr_data,
    input  logic [LOG2_DEPTH-1:0]         rd_ptr,
    output logic [OUT_LANES*LANE_W-1:0]   rd_data
);

    logic [LANE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < IN_LANES; k++) begin
                mem[LOG2_DEPTH'(ptr_add(int'(wr_ptr), k, DEPTH))] <= wr_data[k*LANE_W +: LANE_W];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < OUT_LANES; k++) begin
            rd_data[k*LANE_W +: LANE_W] = mem[LOG2_DEPTH'(ptr_add(int'(rd_ptr), k, DEPTH))];
        end
    end

endmodule

// File: rtl/sync_width_conv_fifo.sv
// rtl/sync_width_conv_fifo.sv - single-clock FIFO with integer-ratio width conversion; SYNC_FIFO_ERR_EN adds sticky err_ovf/err_udf
module sync_width_conv_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int WIDTH_IN    = 32,
    parameter int WIDTH_OUT   = 128,
    localparam int LOG2_DEPTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [WIDTH_IN-1:0]   wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [WIDTH_OUT-1:0]  rd_data,
    output logic [LOG2_DEPTH:0]   count
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                  err_ovf,
    output logic                  err_udf
`endif
);

    localparam int LANE_W    = (WIDTH_IN < WIDTH_OUT) ? WIDTH_IN : WIDTH_OUT;
    localparam int IN_LANES  = lanes_of(WIDTH_IN, LANE_W);
    localparam int OUT_LANES = lanes_of(WIDTH_OUT, LANE_W);
    localparam int CNT_W     = LOG2_DEPTH + 1;

    localparam logic [CNT_W-1:0] WR_LIMIT = CNT_W'(DEPTH - IN_LANES);
    localparam logic [CNT_W-1:0] RD_LIMIT = CNT_W'(OUT_LANES);

    generate
        if (!params_ok(DEPTH, WIDTH_IN, WIDTH_OUT)) begin : g_bad_params
            $error("sync_width_conv_fifo: illegal DEPTH/WIDTH_IN/WIDTH_OUT combination");
        end
    endgenerate

    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic [WIDTH_OUT-1:0]  mem_rd;
    logic [WIDTH_OUT-1:0]  rd_last;
    logic                  wr_fire;
    logic                  rd_fire;

    // Flow control looks only at the registered count: no same-cycle bypass in either direction.
    assign wr_ready = (count <= WR_LIMIT);
    assign rd_valid = (count >= RD_LIMIT);
    assign wr_fire  = wr_valid & wr_ready & ~flush;
    assign rd_fire  = rd_ready & rd_valid & ~flush;
    assign rd_data  = rd_valid ? mem_rd : rd_last;

    sync_fifo_lane_mem #(
        .DEPTH      (DEPTH),
        .LANE_W     (LANE_W),
        .IN_LANES   (IN_LANES),
        .OUT_LANES  (OUT_LANES),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_mem (
        .clk     (clk),
        .we      (wr_fire),
        .wr_ptr  (wr_ptr),
        .wr_data (wr_data),
        .rd_ptr  (rd_ptr),
        .rd_data (mem_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= LOG2_DEPTH'(ptr_add(int'(wr_ptr), IN_LANES, DEPTH));
            if (rd_fire) rd_ptr <= LOG2_DEPTH'(ptr_add(int'(rd_ptr), OUT_LANES, DEPTH));
            count <= count + (wr_fire ? CNT_W'(IN_LANES) : '0) - (rd_fire ? CNT_W'(OUT_LANES) : '0);
        end
    end

    // Keeps the last presented word so rd_data is stable while rd_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_last <= '0;
        end else if (rd_valid) begin
            rd_last <= mem_rd;
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else if (flush) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (wr_valid && !wr_ready) err_ovf <= 1'b1;
            if (rd_ready && !rd_valid) err_udf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sync_width_conv_fifo.sv
// tb/tb_sync_width_conv_fifo.sv - checks an upsizing and a downsizing instance against queue-based lane models
module tb_sync_width_conv_fifo;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         u_flush = 1'b0, u_wr_valid = 1'b0, u_rd_ready = 1'b0;
    logic [31:0]  u_wr_data = '0;
    logic         u_wr_ready, u_rd_valid;
    logic [127:0] u_rd_data;
    logic [4:0]   u_count;

    logic         d_flush = 1'b0, d_wr_valid = 1'b0, d_rd_ready = 1'b0;
    logic [127:0] d_wr_data = '0;
    logic         d_wr_ready, d_rd_valid;
    logic [31:0]  d_rd_data;
    logic [4:0]   d_count;

`ifdef SYNC_FIFO_ERR_EN
    logic u_err_ovf, u_err_udf, d_err_ovf, d_err_udf;
    bit   mu_ovf, mu_udf, md_ovf, md_udf;
`endif

    always #5 clk = ~clk;

    sync_width_conv_fifo #(.DEPTH(16), .WIDTH_IN(32), .WIDTH_OUT(128)) u_up (
        .clk(clk), .rst(rst), .flush(u_flush),
        .wr_valid(u_wr_valid), .wr_ready(u_wr_ready), .wr_data(u_wr_data),
        .rd_valid(u_rd_valid), .rd_ready(u_rd_ready), .rd_data(u_rd_data),
        .count(u_count)
`ifdef SYNC_FIFO_ERR_EN
        , .err_ovf(u_err_ovf), .err_udf(u_err_udf)
`endif
    );

    sync_width_conv_fifo #(.DEPTH(16), .WIDTH_IN(128), .WIDTH_OUT(32)) u_down (
        .clk(clk), .rst(rst), .flush(d_flush),
        .wr_valid(d_wr_valid), .wr_ready(d_wr_ready), .wr_data(d_wr_data),
        .rd_valid(d_rd_valid), .rd_ready(d_rd_ready), .rd_data(d_rd_data),
        .count(d_count)
`ifdef SYNC_FIFO_ERR_EN
        , .err_ovf(d_err_ovf), .err_udf(d_err_udf)
`endif
    );

    int checks = 0;
    int failures = 0;

    logic [31:0]  uq[$];
    logic [31:0]  dq[$];
    logic [127:0] u_last = '0;
    logic [127:0] d_last = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        u_flush = 0; u_wr_valid = 0; u_rd_ready = 0;
        d_flush = 0; d_wr_valid = 0; d_rd_ready = 0;
    endtask

    task automatic reset_models();
        uq.delete(); dq.delete();
        u_last = '0; d_last = '0;
`ifdef SYNC_FIFO_ERR_EN
        mu_ovf = 0; mu_udf = 0; md_ovf = 0; md_udf = 0;
`endif
    endtask

    // One clock: compare against the models at negedge, advance models, return just after posedge.
    task automatic tick();
        bit uv, ur, dv, dr;
        logic [127:0] ue, de;
        @(negedge clk);
        uv = uq.size() >= 4;
        ur = (16 - uq.size()) >= 1;
        dv = dq.size() >= 1;
        dr = (16 - dq.size()) >= 4;
        if (uv) ue = {uq[3], uq[2], uq[1], uq[0]}; else ue = u_last;
        if (dv) de = {96'b0, dq[0]};               else de = d_last;
        check("up_count", u_count, uq.size());
        check("up_rd_valid", u_rd_valid, uv);
        check("up_wr_ready", u_wr_ready, ur);
        check("up_rd_data", u_rd_data, ue);
        check("dn_count", d_count, dq.size());
        check("dn_rd_valid", d_rd_valid, dv);
        check("dn_wr_ready", d_wr_ready, dr);
        check("dn_rd_data", d_rd_data, de);
`ifdef SYNC_FIFO_ERR_EN
        check("up_err_ovf", u_err_ovf, mu_ovf);
        check("up_err_udf", u_err_udf, mu_udf);
        check("dn_err_ovf", d_err_ovf, md_ovf);
        check("dn_err_udf", d_err_udf, md_udf);
        if (u_flush) begin mu_ovf = 0; mu_udf = 0; end
        else begin
            if (u_wr_valid && !ur) mu_ovf = 1;
            if (u_rd_ready && !uv) mu_udf = 1;
        end
        if (d_flush) begin md_ovf = 0; md_udf = 0; end
        else begin
            if (d_wr_valid && !dr) md_ovf = 1;
            if (d_rd_ready && !dv) md_udf = 1;
        end
`endif
        if (uv) u_last = ue;
        if (dv) d_last = de;
        if (u_flush) uq.delete();
        else begin
            if (u_rd_ready && uv) repeat (4) void'(uq.pop_front());
            if (u_wr_valid && ur) uq.push_back(u_wr_data);
        end
        if (d_flush) dq.delete();
        else begin
            if (d_rd_ready && dv) void'(dq.pop_front());
            if (d_wr_valid && dr) for (int k = 0; k < 4; k++) dq.push_back(d_wr_data[k*32 +: 32]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic up_write(input logic [31:0] data);
        idle(); u_wr_valid = 1; u_wr_data = data; tick(); idle();
    endtask

    task automatic upsize_scenario(input string pfx);
        up_write(32'h11111111);
        up_write(32'h22222222);
        up_write(32'h33333333);
        check({pfx, "_valid3"}, u_rd_valid, 1'b0);
        up_write(32'h44444444);
        check({pfx, "_valid4"}, u_rd_valid, 1'b1);
        check({pfx, "_data4"}, u_rd_data, 128'h44444444_33333333_22222222_11111111);
        check({pfx, "_count4"}, u_count, 5'd4);
        idle(); u_rd_ready = 1; tick(); idle();
        check({pfx, "_count_drained"}, u_count, 5'd0);
    endtask

    initial begin
        reset_models();
        idle();
        repeat (2) @(posedge clk);
        #3 rst = 0;
        @(posedge clk); #1;
        check("reset_count", u_count, 5'd0);
        check("reset_rd_data", u_rd_data, 128'd0);
        check("reset_wr_ready", u_wr_ready, 1'b1);

        upsize_scenario("s1");

        // Downsize
        idle(); d_wr_valid = 1;
        d_wr_data = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        tick(); idle();
        check("dn_first", d_rd_data, 32'hAAAAAAAA);
        d_rd_ready = 1; tick();
        check("dn_second", d_rd_data, 32'hBBBBBBBB);
        tick();
        check("dn_third", d_rd_data, 32'hCCCCCCCC);
        tick();
        check("dn_fourth", d_rd_data, 32'hDDDDDDDD);
        tick(); idle();
        check("dn_empty_valid", d_rd_valid, 1'b0);
        check("dn_empty_count", d_count, 5'd0);

        // Full and wrap
        for (int i = 0; i < 16; i++) up_write(32'h10000000 + i);
        check("full_wr_ready", u_wr_ready, 1'b0);
        check("full_count", u_count, 5'd16);
        up_write(32'hDEADBEEF);
        check("full_17th_ignored", u_count, 5'd16);
        check("full_first_word", u_rd_data, 128'h10000003_10000002_10000001_10000000);
        idle(); u_rd_ready = 1; repeat (4) tick(); idle();
        for (int i = 0; i < 8; i++) up_write(32'h20000000 + i);
        check("wrap_first_word", u_rd_data, 128'h20000003_20000002_20000001_20000000);
        idle(); u_rd_ready = 1; repeat (2) tick(); idle();
        check("wrap_drained", u_count, 5'd0);

        // Simultaneous
        for (int i = 0; i < 8; i++) up_write(32'h30000000 + i);
        idle(); u_wr_valid = 1; u_wr_data = 32'h30000008; u_rd_ready = 1; tick(); idle();
        check("simul_count", u_count, 5'd5);

        // Flush with a concurrent write
        for (int i = 0; i < 7; i++) up_write(32'h40000000 + i);
        check("pre_flush_count", u_count, 5'd12);
        idle(); u_flush = 1; u_wr_valid = 1; u_wr_data = 32'h5A5A5A5A; tick(); idle();
        check("flush_count", u_count, 5'd0);
        check("flush_rd_valid", u_rd_valid, 1'b0);
        check("flush_wr_ready", u_wr_ready, 1'b1);
        tick();
        check("flush_write_lost", u_count, 5'd0);

        // Asynchronous reset mid-stream
        up_write(32'h61616161);
        up_write(32'h62626262);
        idle(); d_wr_valid = 1; d_wr_data = {$urandom, $urandom, $urandom, $urandom}; tick(); idle();
        #2 rst = 1;
        #1;
        check("arst_up_count", u_count, 5'd0);
        check("arst_up_rd_valid", u_rd_valid, 1'b0);
        check("arst_up_wr_ready", u_wr_ready, 1'b1);
        check("arst_up_rd_data", u_rd_data, 128'd0);
        check("arst_dn_count", d_count, 5'd0);
        check("arst_dn_rd_data", d_rd_data, 32'd0);
        reset_models();
        @(posedge clk);
        #3 rst = 0;
        upsize_scenario("s6");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            u_wr_valid = ($urandom_range(0, 3) != 0);
            u_rd_ready = ($urandom_range(0, 2) != 0);
            u_wr_data  = $urandom;
            u_flush    = ($urandom_range(0, 59) == 0);
            d_wr_valid = ($urandom_range(0, 2) != 0);
            d_rd_ready = ($urandom_range(0, 3) != 0);
            d_wr_data  = {$urandom, $urandom, $urandom, $urandom};
            d_flush    = ($urandom_range(0, 59) == 0);
            tick();
        end
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
